seg7_pattern_decoder: RTL and testbench
=======================================

# seg7_pattern_decoder

Receive-side counterpart of the one-digit 7-segment display driver. It samples the 8-bit segment pattern (pgfe_dcba) once per 1 s tick and decodes it back to a 4-bit digit. It then checks that successive digits follow the display counter's wrap sequence (0,1,…,MAX_DIGIT,0,…) and reports lock, sequence errors and a saturating error count. It sits on the display bus in parallel with the LED pins and serves as the on-board self-check / loopback monitor for the display path.

## Interface
Parameters:
- MAX_DIGIT, 3: last digit of the display count; expected successor of MAX_DIGIT is 0. Legal range 1..9.
- ERR_LIMIT, 3: consecutive mismatches in LOCK that drop lock. Legal range ≥1.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- Clock and reset: clock w_clk_1s; reset w_rst, asynchronous, active-low.
- w_clk_1s  in  1  sample clock; one cycle = one display update.
- w_rst  in  1  asynchronous active-low reset.
- seg_in  in  8  segment pattern, bit7 = p (dp), bit0 = a; same clock domain as the display driver.
- digit_out  out  4  last decoded digit; holds its value on invalid or blank input.
- digit_valid  out  1  high for the cycle after a recognised digit code is sampled.
- blank  out  1  high for the cycle after 8'h00 is sampled.
- locked  out  1  high while in LOCK.
- seq_err  out  1  one-cycle pulse per sequence error.
- err_cnt  out  ERR_CNT_W  total sequence errors, saturating at all-ones.

## Operation
- Code set, full 8-bit match with dp included:
  - 0 = 8'h3F; 1 = 8'h06; 2 = 8'h3B or 8'h5B; 3 = 8'hFF or 8'h4F.
  - 4 = 8'h66; 5 = 8'h6D; 6 = 8'h7D; 7 = 8'h07; 8 = 8'h7F; 9 = 8'h6F.
  - 8'h00 = blank.
  - Any other value = invalid.
- Decoded digits above MAX_DIGIT are valid for digit_out but always count as mismatches in LOCK.
- Internal registers:
  - state ∈ {IDLE, ACQ, LOCK}.
  - expected (4 b).
  - miss_cnt, width clog2(ERR_LIMIT+1).
- IDLE:
  - Valid digit d: go to ACQ, expected = succ(d).
  - Blank or invalid: stay in IDLE.
- ACQ:
  - Valid d == expected: go to LOCK, expected = succ(d), miss_cnt = 0.
  - Valid d != expected: stay in ACQ, expected = succ(d).
  - Invalid: go to IDLE.
  - Blank: go to IDLE.
- LOCK:
  - Match: expected = succ(d), miss_cnt = 0.
  - Mismatch (valid wrong digit, repeated digit, or invalid code):
    - Pulse seq_err and increment err_cnt (saturating).
    - miss_cnt += 1.
    - expected = succ(d) if valid, else succ(expected).
    - If miss_cnt reaches ERR_LIMIT, go to IDLE and clear miss_cnt.
  - Blank: go to IDLE with no error. A blank is a deliberate display clear.
- succ(x) = (x == MAX_DIGIT) ? 0 : x+1. This is 4-bit arithmetic; no overflow is possible given the MAX_DIGIT range.
- err_cnt is cleared only by reset. It is never cleared by loss of lock.

## Timing
- All outputs are registered and update on the rising edge of w_clk_1s after the edge that samples seg_in, giving a latency of 1 cycle (1 s).
- seg_in is driven by a register on the same clock. The decoder therefore observes the pattern launched on the previous edge, and the end-to-end latency from the driver's counter to digit_out is 2 cycles.
- Reset values, asserted asynchronously when w_rst = 0:
  - state = IDLE, expected = 0, miss_cnt = 0.
  - digit_out = 0, digit_valid = 0, blank = 0, locked = 0, seq_err = 0, err_cnt = 0.
- Reset is released synchronously to the next edge. A reset asserted mid-LOCK drops locked and clears err_cnt immediately.
- Simultaneous events in one sample: blank takes priority over all LOCK logic. Reaching ERR_LIMIT and pulsing seq_err happen on the same edge, so locked falls with the final seq_err pulse.
- locked asserts on the edge following the second consecutive in-sequence digit.

## Structure
- Package seg7_pkg holds:
  - the code constants (SEG_0…SEG_9, SEG_2_ALT, SEG_3_ALT, SEG_BLANK);
  - the state enum;
  - the succ() function.
- Sub-module seg7_code_decode is a pure combinational lookup from seg_in to {valid, blank, digit[3:0]}. It is shared with any future multi-digit scanner.
- The top level contains the FSM, the counters and the output registers.

## Test plan
- Reset, then seg_in = 3F, 06, 3B, FF, 3F → digit_out 0,1,2,3,0 at 1 cycle latency; locked rises after the 06 sample; seq_err never pulses; err_cnt = 0.
- While locked (last digit 1), seg_in = 06 repeated once → one seq_err pulse, err_cnt = 1. Then 3B, FF → miss_cnt clears and locked stays high.
- While locked, seg_in = 8'hA5 three consecutive times with ERR_LIMIT = 3 → three seq_err pulses, err_cnt = 3, locked falls on the third pulse, and digit_out holds its last value.
- While locked, seg_in = 00 → blank = 1 for one cycle, locked = 0, no seq_err. Then 3F, 06 → relock.
- Drive 2^ERR_CNT_W+5 mismatches (ERR_CNT_W = 4) → err_cnt saturates at 4'hF.
- Assert w_rst between clock edges while locked → all outputs go to their reset values without waiting for a clock edge; the next 3F, 06 sequence relocks.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment loopback decoder: segment codes,
// FSM state encoding and the display counter's successor function.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h3B;
  localparam logic [7:0] SEG_2_ALT = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'hFF;
  localparam logic [7:0] SEG_3_ALT = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  // Next digit the display counter shows after x, wrapping at max_d.
  function automatic logic [3:0] succ(input logic [3:0] x, input logic [3:0] max_d);
    return (x == max_d) ? 4'd0 : x + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder_if.sv
// Display-bus tap: segment pattern in, decoded digit and lock status out.
interface seg7_pattern_decoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           seg_in;
  logic [3:0]           digit_out;
  logic                 digit_valid;
  logic                 blank;
  logic                 locked;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output seg_in,
    input  digit_out, digit_valid, blank, locked, seq_err, err_cnt
  );

  modport slave (
    input  seg_in,
    output digit_out, digit_valid, blank, locked, seq_err, err_cnt
  );
endinterface

// File: rtl/seg7_code_decode.sv
// Combinational lookup from a full 8-bit segment pattern (dp included)
// to {valid, blank, digit}; anything not in the code set is invalid.
module seg7_code_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg_in,
  output logic       valid,
  output logic       blank,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    digit = 4'd0;
    case (seg_in)
      SEG_0:            digit = 4'd0;
      SEG_1:            digit = 4'd1;
      SEG_2, SEG_2_ALT: digit = 4'd2;
      SEG_3, SEG_3_ALT: digit = 4'd3;
      SEG_4:            digit = 4'd4;
      SEG_5:            digit = 4'd5;
      SEG_6:            digit = 4'd6;
      SEG_7:            digit = 4'd7;
      SEG_8:            digit = 4'd8;
      SEG_9:            digit = 4'd9;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:          valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Loopback monitor for the one-digit display: decodes each sampled pattern
// and checks it follows the 0..MAX_DIGIT wrap sequence.
//
// state   | meaning
// IDLE    | no sequence reference; waiting for any valid digit
// ACQ     | one digit seen; waiting for its successor to confirm lock
// LOCK    | sequence tracked; mismatches counted, ERR_LIMIT in a row drops lock
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int MAX_DIGIT = 3,
  parameter int ERR_LIMIT = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   w_clk_1s,
  input  logic                   w_rst,
  seg7_pattern_decoder_if.slave  bus
);

  localparam int                MISS_W    = $clog2(ERR_LIMIT + 1);
  localparam logic [3:0]        MAX_D     = 4'(MAX_DIGIT);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(ERR_LIMIT - 1);

  logic       dec_valid;
  logic       dec_blank;
  logic [3:0] dec_digit;

  state_e               state_q,       state_d;
  logic [3:0]           expected_q,    expected_d;
  logic [MISS_W-1:0]    miss_q,        miss_d;
  logic [3:0]           digit_out_q,   digit_out_d;
  logic                 digit_valid_q, digit_valid_d;
  logic                 blank_q,       blank_d;
  logic                 locked_q,      locked_d;
  logic                 seq_err_q,     seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,     err_cnt_d;

  seg7_code_decode u_code_decode (
    .seg_in (bus.seg_in),
    .valid  (dec_valid),
    .blank  (dec_blank),
    .digit  (dec_digit)
  );

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    miss_d        = miss_q;
    digit_out_d   = dec_valid ? dec_digit : digit_out_q;
    digit_valid_d = dec_valid;
    blank_d       = dec_blank;
    seq_err_d     = 1'b0;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (dec_valid) begin
          state_d    = ST_ACQ;
          expected_d = succ(dec_digit, MAX_D);
        end
      end
      ST_ACQ: begin
        if (dec_valid) begin
          expected_d = succ(dec_digit, MAX_D);
          if (dec_digit == expected_q) begin
            state_d = ST_LOCK;
            miss_d  = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        // A blank is a deliberate display clear, not a fault.
        if (dec_blank) begin
          state_d = ST_IDLE;
          miss_d  = '0;
        end else if (dec_valid && (dec_digit == expected_q) && (dec_digit <= MAX_D)) begin
          expected_d = succ(dec_digit, MAX_D);
          miss_d     = '0;
        end else begin
          seq_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          expected_d = dec_valid ? succ(dec_digit, MAX_D) : succ(expected_q, MAX_D);
          if (miss_q == MISS_LAST) begin
            state_d = ST_IDLE;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge w_clk_1s or negedge w_rst) begin
    if (!w_rst) begin
      state_q       <= ST_IDLE;
      expected_q    <= 4'd0;
      miss_q        <= '0;
      digit_out_q   <= 4'd0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      locked_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      miss_q        <= miss_d;
      digit_out_q   <= digit_out_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      locked_q      <= locked_d;
      seq_err_q     <= seq_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.digit_out   = digit_out_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.blank       = blank_q;
  assign bus.locked      = locked_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: per-cycle compare against a sequence model
// plus hand-computed literal expectations on a directed pattern stream.
module tb_seg7_pattern_decoder;

  localparam int MAX_DIGIT = 3;
  localparam int ERR_LIMIT = 3;
  localparam int ERR_CNT_W = 4;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic w_clk_1s = 1'b0;
  logic w_rst    = 1'b0;

  seg7_pattern_decoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  seg7_pattern_decoder #(
    .MAX_DIGIT (MAX_DIGIT),
    .ERR_LIMIT (ERR_LIMIT),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .w_clk_1s (w_clk_1s),
    .w_rst    (w_rst),
    .bus      (bus)
  );

  always #5 w_clk_1s = ~w_clk_1s;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: -1 = invalid code, -2 = blank, otherwise the digit.
  int code_tab [256];
  int m_mode;      // 0 idle, 1 acquiring, 2 locked
  int m_next;      // digit the display should show next
  int m_misses;
  int m_digit, m_dv, m_blank, m_locked, m_seqerr, m_errs;

  function automatic int nxt(input int x);
    return (x == MAX_DIGIT) ? 0 : x + 1;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_next = 0; m_misses = 0;
    m_digit = 0; m_dv = 0; m_blank = 0; m_locked = 0; m_seqerr = 0; m_errs = 0;
  endfunction

  function automatic void model_step(input int pat);
    int c;
    c        = code_tab[pat];
    m_dv     = (c >= 0) ? 1 : 0;
    m_blank  = (c == -2) ? 1 : 0;
    m_seqerr = 0;
    if (c >= 0) m_digit = c;
    if (m_mode == 0) begin
      if (c >= 0) begin m_mode = 1; m_next = nxt(c); end
    end else if (m_mode == 1) begin
      if (c < 0) m_mode = 0;
      else begin
        if (c == m_next) begin m_mode = 2; m_misses = 0; end
        m_next = nxt(c);
      end
    end else begin
      if (c == -2) begin
        m_mode = 0; m_misses = 0;
      end else if (c >= 0 && c <= MAX_DIGIT && c == m_next) begin
        m_next = nxt(c); m_misses = 0;
      end else begin
        m_seqerr = 1;
        m_errs   = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
        m_next   = (c >= 0) ? nxt(c) : nxt(m_next);
        m_misses++;
        if (m_misses >= ERR_LIMIT) begin m_mode = 0; m_misses = 0; end
      end
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) code_tab[i] = -1;
    code_tab[8'h3F] = 0; code_tab[8'h06] = 1;
    code_tab[8'h3B] = 2; code_tab[8'h5B] = 2;
    code_tab[8'hFF] = 3; code_tab[8'h4F] = 3;
    code_tab[8'h66] = 4; code_tab[8'h6D] = 5; code_tab[8'h7D] = 6;
    code_tab[8'h07] = 7; code_tab[8'h7F] = 8; code_tab[8'h6F] = 9;
    code_tab[8'h00] = -2;
    model_reset();
  end

  always @(negedge w_rst) model_reset();

  // Every cycle: advance the model with the pattern the DUT samples, then compare.
  initial begin
    forever begin
      @(posedge w_clk_1s);
      if (!w_rst) model_reset();
      else model_step(int'(bus.seg_in));
      #1;
      chk("mdl_digit_out",   int'(bus.digit_out),   m_digit);
      chk("mdl_digit_valid", int'(bus.digit_valid), m_dv);
      chk("mdl_blank",       int'(bus.blank),       m_blank);
      chk("mdl_locked",      int'(bus.locked),      m_locked);
      chk("mdl_seq_err",     int'(bus.seq_err),     m_seqerr);
      chk("mdl_err_cnt",     int'(bus.err_cnt),     m_errs);
    end
  end

  // Drive one pattern and check the literal outputs one cycle later.
  task automatic step(input logic [7:0] v, input int dig, input int dv, input int bl,
                      input int lk, input int se, input int ec);
    @(negedge w_clk_1s);
    bus.seg_in = v;
    @(posedge w_clk_1s);
    #2;
    chk($sformatf("lit_digit_%02h", v), int'(bus.digit_out),   dig);
    chk($sformatf("lit_valid_%02h", v), int'(bus.digit_valid), dv);
    chk($sformatf("lit_blank_%02h", v), int'(bus.blank),       bl);
    chk($sformatf("lit_lock_%02h",  v), int'(bus.locked),      lk);
    chk($sformatf("lit_serr_%02h",  v), int'(bus.seq_err),     se);
    chk($sformatf("lit_ecnt_%02h",  v), int'(bus.err_cnt),     ec);
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge w_clk_1s);
    bus.seg_in = v;
  endtask

  typedef struct { logic [7:0] v; int dig, dv, bl, lk, se, ec; } vec_t;
  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.seg_in = 8'h00;
    repeat (3) @(posedge w_clk_1s);
    #2;
    chk("rst_digit_out", int'(bus.digit_out), 0);
    chk("rst_locked",    int'(bus.locked),    0);
    chk("rst_err_cnt",   int'(bus.err_cnt),   0);
    @(negedge w_clk_1s);
    w_rst = 1'b1;

    //           v      dig dv bl lk se ec
    vecs = '{
      '{8'h3F, 0, 1, 0, 0, 0, 0}, '{8'h06, 1, 1, 0, 1, 0, 0},
      '{8'h3B, 2, 1, 0, 1, 0, 0}, '{8'hFF, 3, 1, 0, 1, 0, 0},
      '{8'h3F, 0, 1, 0, 1, 0, 0}, '{8'h06, 1, 1, 0, 1, 0, 0},
      '{8'h06, 1, 1, 0, 1, 1, 1}, '{8'h3B, 2, 1, 0, 1, 0, 1},
      '{8'hFF, 3, 1, 0, 1, 0, 1},
      '{8'hA5, 3, 0, 0, 1, 1, 2}, '{8'hA5, 3, 0, 0, 1, 1, 3},
      '{8'hA5, 3, 0, 0, 0, 1, 4},
      '{8'h3F, 0, 1, 0, 0, 0, 4}, '{8'h06, 1, 1, 0, 1, 0, 4},
      '{8'h00, 1, 0, 1, 0, 0, 4},
      '{8'h3F, 0, 1, 0, 0, 0, 4}, '{8'h06, 1, 1, 0, 1, 0, 4},
      '{8'h5B, 2, 1, 0, 1, 0, 4}, '{8'h4F, 3, 1, 0, 1, 0, 4},
      '{8'h66, 4, 1, 0, 1, 1, 5}, '{8'h6D, 5, 1, 0, 1, 1, 6},
      '{8'h3F, 0, 1, 0, 0, 1, 7},
      '{8'h7D, 6, 1, 0, 0, 0, 7}, '{8'h3F, 0, 1, 0, 0, 0, 7},
      '{8'hA5, 0, 0, 0, 0, 0, 7},
      '{8'h06, 1, 1, 0, 0, 0, 7}, '{8'h3B, 2, 1, 0, 1, 0, 7}
    };
    foreach (vecs[i])
      step(vecs[i].v, vecs[i].dig, vecs[i].dv, vecs[i].bl, vecs[i].lk, vecs[i].se, vecs[i].ec);

    // Five rounds of three invalid codes each push the counter past its ceiling.
    for (int r = 0; r < 5; r++) begin
      if (r != 0) begin
        drive(8'h3F);
        drive(8'h06);
      end
      repeat (3) drive(8'hA5);
    end
    @(posedge w_clk_1s);
    #2;
    chk("sat_err_cnt", int'(bus.err_cnt), ERR_MAX);
    chk("sat_locked",  int'(bus.locked),  0);

    step(8'h3F, 0, 1, 0, 0, 0, ERR_MAX);
    step(8'h06, 1, 1, 0, 1, 0, ERR_MAX);

    // Asynchronous reset mid-cycle while locked.
    #1;
    w_rst = 1'b0;
    #1;
    chk("arst_locked",    int'(bus.locked),      0);
    chk("arst_err_cnt",   int'(bus.err_cnt),     0);
    chk("arst_digit_out", int'(bus.digit_out),   0);
    chk("arst_valid",     int'(bus.digit_valid), 0);
    @(negedge w_clk_1s);
    w_rst = 1'b1;
    step(8'h3F, 0, 1, 0, 0, 0, 0);
    step(8'h06, 1, 1, 0, 1, 0, 0);
    step(8'h3B, 2, 1, 0, 1, 0, 0);

    @(negedge w_clk_1s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
